apb_sram_slave: RTL and testbench

Parametrised APB4 completer fronting a byte-writable on-chip SRAM. It generalises the team's fixed 256x32 APB memory slave with configurable data width and depth, programmable wait states, and byte-address decode with alignment checks. It also adds a privileged-write protected region and a saturating error counter. It sits on the peripheral APB segment behind the bridge, one instance per memory window.

---
 rtl/apb_sram_pkg.sv | 22 ++
 rtl/apb_sram_bytemem.sv | 26 ++
 rtl/apb_sram_slave.sv | 163 ++++++++++++++++
 tb/tb_apb_sram_slave.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_sram_pkg.sv
// rtl/apb_sram_pkg.sv - shared types and helpers for the APB SRAM completer
package apb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_e;

  // Bit positions inside the registered error-cause vector
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;
  localparam int ERR_PROT     = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/apb_sram_bytemem.sv
// rtl/apb_sram_bytemem.sv - DEPTH x DATA_WIDTH RAM, byte write enables, async read
module apb_sram_bytemem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = 8
) (
  input  logic                    clk_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/apb_sram_slave.sv
// rtl/apb_sram_slave.sv - APB4 completer fronting a byte-writable SRAM window
module apb_sram_slave
  import apb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int PROT_WORDS  = 0,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AL = clog2(NB);
  localparam int IW = ADDR_WIDTH - AL;
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            cause_q, cause_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         strb_q, strb_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [IW-1:0]         addr_idx;
  logic                  misalign, out_of_range, in_prot;
  logic [2:0]            cause_now;
  logic [AW-1:0]         mem_addr;
  logic [NB-1:0]         mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_prot;

  assign addr_idx    = PADDR[ADDR_WIDTH-1:AL];
  assign unused_prot = ^PPROT[2:1];

  generate
    if (AL > 0) begin : g_align
      assign misalign = |PADDR[AL-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
    if (PROT_WORDS > 0) begin : g_prot
      assign in_prot = 64'(addr_idx) < 64'(PROT_WORDS);
    end else begin : g_no_prot
      assign in_prot = 1'b0;
    end
  endgenerate

  assign out_of_range = 64'(addr_idx) >= 64'(DEPTH);

  always_comb begin
    cause_now               = '0;
    cause_now[ERR_MISALIGN] = misalign;
    cause_now[ERR_RANGE]    = out_of_range;
    cause_now[ERR_PROT]     = PWRITE & in_prot & ~PPROT[0];
  end

  // Setup reads and READY writes never coincide, so one address port suffices
  assign mem_addr = (state_q == READY) ? idx_q : addr_idx[AW-1:0];

  apb_sram_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk_i   (PCLK),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cause_q   <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prdata_d  = prdata_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          cause_d = cause_now;
          idx_d   = addr_idx[AW-1:0];
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          if (!PWRITE) prdata_d = (|cause_now) ? '0 : mem_rdata;
          if (WAIT_STATES == 0) begin
            state_d = READY;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL)            state_d = IDLE;
        else if (cnt_q == '0) state_d = READY;
        else                  cnt_d   = cnt_q - 4'd1;
      end
      READY: begin
        state_d = IDLE;
        if ((|cause_q) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PREADY  = (state_q == READY);
    PSLVERR = PREADY & (|cause_q);
    mem_we  = (PREADY && write_q && !(|cause_q)) ? strb_q : '0;
  end

  assign PRDATA    = prdata_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_apb_sram_slave.sv
// tb/tb_apb_sram_slave.sv - scoreboard bench for apb_sram_slave (two configurations)
module tb_apb_sram_slave;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  apb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
    .WAIT_STATES(0), .PROT_WORDS(4), .ERR_CNT_W(8)
  ) dut0 (
    .PCLK(clk), .PRESET(rst[0]), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .err_count(cnt0)
  );

  apb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
    .WAIT_STATES(3), .PROT_WORDS(0), .ERR_CNT_W(2)
  ) dut1 (
    .PCLK(clk), .PRESET(rst[1]), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PPROT(pprot), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1),
    .err_count(cnt1)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][256];
  logic [31:0] last_rd [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int pw_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  function automatic logic get_err(input int d);
    return (d == 0) ? pslverr0 : pslverr1;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? prdata0 : prdata1;
  endfunction

  function automatic int get_cnt(input int d);
    return (d == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  // Called just after a rising edge; returns just after the completion edge
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [2:0] prot, input string name,
                      output logic [31:0] rd_obs);
    exp_t        e;
    logic        err;
    int          idx;
    int          cyc;
    bit          done;
    logic [31:0] rd;
    logic        se;
    idx = int'(addr[31:2]);
    err = (addr[1:0] != 2'b00) || (idx >= 256) ||
          (wr && (idx < pw_of(d)) && !prot[0]);
    e.cycles = 2 + ws_of(d);
    e.slverr = err;
    if (wr) begin
      e.rdata = last_rd[d];
      if (!err) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end else begin
      e.rdata    = err ? 32'h0 : model[d][idx];
      last_rd[d] = e.rdata;
    end
    sb.push_back(e);

    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc  = 1;
    done = 1'b0;
    rd   = '0;
    se   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (get_ready(d) === 1'b1) begin
        rd   = get_rdata(d);
        se   = get_err(d);
        done = 1'b1;
      end else begin
        tests++;
        if (get_err(d) !== 1'b0) begin
          fails++;
          $display("FAIL %s pslverr_while_not_ready: got %b want 0", name, get_err(d));
        end
      end
    end
    if (done) begin
      @(posedge clk); #1;
    end
    psel[d] = 1'b0; penable = 1'b0;
    e = sb.pop_front();
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s timeout: no PREADY within 40 cycles", name);
    end else begin
      tests += 3;
      if (cyc !== e.cycles) begin
        fails++;
        $display("FAIL %s latency: got %0d want %0d", name, cyc, e.cycles);
      end
      if (se !== e.slverr) begin
        fails++;
        $display("FAIL %s pslverr: got %b want %b", name, se, e.slverr);
      end
      if (rd !== e.rdata) begin
        fails++;
        $display("FAIL %s prdata: got %h want %h", name, rd, e.rdata);
      end
    end
    rd_obs = rd;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      tests += 4;
      if (get_ready(d) !== 1'b0) begin
        fails++; $display("FAIL reset_pready dut%0d: got %b want 0", d, get_ready(d));
      end
      if (get_err(d) !== 1'b0) begin
        fails++; $display("FAIL reset_pslverr dut%0d: got %b want 0", d, get_err(d));
      end
      if (get_rdata(d) !== 32'h0) begin
        fails++; $display("FAIL reset_prdata dut%0d: got %h want 0", d, get_rdata(d));
      end
      if (get_cnt(d) !== 0) begin
        fails++; $display("FAIL reset_err_count dut%0d: got %0d want 0", d, get_cnt(d));
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] r;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, "basic_wr", r);
    @(negedge clk);
    tests++;
    if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin
      fails++; $display("FAIL basic_pready_fall: got %b/%b want 0/0", pready0, pslverr0);
    end
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, "basic_rd", r);
    tests++;
    if (r !== 32'hDEADBEEF) begin
      fails++; $display("FAIL basic_value: got %h want deadbeef", r);
    end
  endtask

  task automatic test_partial();
    logic [31:0] r;
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 3'b000, "part_full", r);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, "part_strb", r);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, "part_rd", r);
    tests++;
    if (r !== 32'h11BB33DD) begin
      fails++; $display("FAIL partial_value: got %h want 11bb33dd", r);
    end
    xfer(0, 1'b1, 32'h10, 32'h0, 4'h0, 3'b000, "zero_strb_wr", r);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, "zero_strb_rd", r);
  endtask

  task automatic test_errors();
    logic [31:0] r;
    xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 3'b001, "err_pre0", r);
    xfer(0, 1'b1, 32'h8, 32'h55AA55AA, 4'hF, 3'b001, "err_pre8", r);
    xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, "err_range_rd", r);
    xfer(0, 1'b1, 32'h3, 32'hFFFFFFFF, 4'hF, 3'b001, "err_misalign_wr", r);
    xfer(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 3'b000, "err_prot_wr", r);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, "err_chk0", r);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, "err_chk8", r);
    tests++;
    if (cnt0 !== 8'd3) begin
      fails++; $display("FAIL err_count_three: got %0d want 3", cnt0);
    end
    xfer(0, 1'b1, 32'h8, 32'h00000077, 4'hF, 3'b001, "prot_ok_wr", r);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, "prot_ok_rd", r);
    tests++;
    if (cnt0 !== 8'd3) begin
      fails++; $display("FAIL err_count_after_ok: got %0d want 3", cnt0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      xfer(0, 1'b1, 32'h80 + 32'(i * 4), $urandom, 4'(i + 8), 3'b000, "b2b_wr", r);
      xfer(0, 1'b0, 32'h80 + 32'(i * 4), 32'h0, 4'h0, 3'b000, "b2b_rd", r);
    end
  endtask

  task automatic test_protocol_violation();
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (pready0 !== 1'b0) begin
        fails++; $display("FAIL protocol_violation_pready: got %b want 0", pready0);
      end
    end
    @(posedge clk); #1;
    psel[0] = 1'b0; penable = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [31:0] r;
    xfer(1, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 3'b000, "ws_wr", r);
    xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, "ws_rd", r);
    tests++;
    if (r !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL ws_value: got %h want a5a5a5a5", r);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] r;
    for (int i = 0; i < 5; i++) begin
      xfer(1, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, "sat_rd", r);
      if (i == 1) begin
        tests++;
        if (cnt1 !== 2'd2) begin
          fails++; $display("FAIL sat_count_two: got %0d want 2", cnt1);
        end
      end
    end
    tests++;
    if (cnt1 !== 2'd3) begin
      fails++; $display("FAIL sat_count: got %0d want 3", cnt1);
    end
  endtask

  task automatic test_psel_abort();
    logic [31:0] r;
    xfer(1, 1'b1, 32'h44, 32'h0BADF00D, 4'hF, 3'b000, "pabort_pre", r);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h44;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (pready1 !== 1'b0) begin
        fails++; $display("FAIL pabort_pready: got %b want 0", pready1);
      end
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000, "pabort_rd", r);
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    xfer(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 3'b000, "rabort_pre", r);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, "rabort_pre_rd", r);
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40;
    pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    psel[1] = 1'b0; penable = 1'b0;
    #1;
    tests += 3;
    if (pready1 !== 1'b0) begin
      fails++; $display("FAIL rabort_pready: got %b want 0", pready1);
    end
    if (prdata1 !== 32'h0) begin
      fails++; $display("FAIL rabort_prdata: got %h want 0", prdata1);
    end
    if (cnt1 !== 2'd0) begin
      fails++; $display("FAIL rabort_err_count: got %0d want 0", cnt1);
    end
    @(posedge clk); #1;
    rst[1] = 1'b0;
    last_rd[1] = 32'h0;
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, "rabort_rd", r);
  endtask

  initial begin
    rst = 2'b11; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 2'b00;
    @(posedge clk); #1;
    test_basic();
    test_partial();
    test_errors();
    test_back_to_back();
    test_protocol_violation();
    test_wait_states();
    test_saturation();
    test_psel_abort();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
